core_pipe_ctrl: RTL and testbench

CORE_PIPE_CTRL -- requirements
Module: core_pipe_ctrl

---
 rtl/core_pkg.sv | 14 +
 rtl/core_sat_cnt.sv | 29 ++
 rtl/core_pipe_ctrl.sv | 152 +++++++++++++++
 tb/tb_core_pipe_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline control slice.
//   pipe_ctrl_state_t : pipeline controller FSM state encoding
//   STALL_CNT_W       : width of the performance stall counter
package core_pkg;

  localparam int STALL_CNT_W = 32;

  typedef enum logic [1:0] {
    RUN       = 2'd0,  // normal issue
    TRAP_PEND = 2'd1,  // trap accepted, waiting for the data access to finish
    DRAIN     = 2'd2   // redirected, discarding the wrong-path fetch in flight
  } pipe_ctrl_state_t;

endpackage

// File: rtl/core_sat_cnt.sv
// Saturating up-counter.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears the count
//   inc   : add one this cycle (ignored once the count is all ones)
//   clr   : synchronous clear, wins over inc
//   count : current count value
module core_sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/core_pipe_ctrl.sv
// Pipeline hazard / redirect controller for a 5-stage core.
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   insert_nop       : load-use hazard from the ID-stage detector
//   ex_jump          : taken branch / jump resolved in EX
//   trap_req         : trap or interrupt accepted at MEM
//   ifu_ready        : instruction bus delivers a fetch this cycle
//   lsu_busy         : MEM-stage data access still outstanding
//   pc_hold, fd_hold, de_hold, em_hold     : freeze PC / pipeline register
//   fd_flush, de_flush, em_flush, mw_flush : load a bubble into the register
//   redirect, redirect_src                 : PC loads target (0 jump, 1 trap)
//   stall_cnt        : saturating count of cycles with pc_hold=1
// Control outputs are combinational from the registered state and the inputs.
module core_pipe_ctrl
  import core_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   insert_nop,
  input  logic                   ex_jump,
  input  logic                   trap_req,
  input  logic                   ifu_ready,
  input  logic                   lsu_busy,
  output logic                   pc_hold,
  output logic                   fd_hold,
  output logic                   de_hold,
  output logic                   em_hold,
  output logic                   fd_flush,
  output logic                   de_flush,
  output logic                   em_flush,
  output logic                   mw_flush,
  output logic                   redirect,
  output logic                   redirect_src,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_ctrl_state_t state, next_state;

  logic pc_hold_c, fd_hold_c, de_hold_c, em_hold_c;
  logic fd_flush_c, de_flush_c, em_flush_c, mw_flush_c;
  logic redirect_c, redirect_src_c;
  logic trap_live;

  // A trap is live when newly requested or already latched in TRAP_PEND.
  assign trap_live = trap_req || (state == TRAP_PEND);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state     = state;
    pc_hold_c      = 1'b0;
    fd_hold_c      = 1'b0;
    de_hold_c      = 1'b0;
    em_hold_c      = 1'b0;
    fd_flush_c     = 1'b0;
    de_flush_c     = 1'b0;
    em_flush_c     = 1'b0;
    mw_flush_c     = 1'b0;
    redirect_c     = 1'b0;
    redirect_src_c = 1'b0;

    if (trap_live && lsu_busy) begin
      // Trap must wait for the data access: freeze everything, bubble WB.
      pc_hold_c  = 1'b1;
      fd_hold_c  = 1'b1;
      de_hold_c  = 1'b1;
      em_hold_c  = 1'b1;
      mw_flush_c = 1'b1;
      // A stale fetch may still arrive while draining; keep discarding it.
      if (state == DRAIN) fd_flush_c = 1'b1;
      next_state = TRAP_PEND;
    end else if (trap_live) begin
      // Take the trap: redirect wins over the drain's PC freeze.
      redirect_c     = 1'b1;
      redirect_src_c = 1'b1;
      fd_flush_c     = 1'b1;
      de_flush_c     = 1'b1;
      em_flush_c     = 1'b1;
      mw_flush_c     = 1'b1;
      next_state     = ifu_ready ? RUN : DRAIN;
    end else if (state == DRAIN) begin
      pc_hold_c  = 1'b1;
      fd_flush_c = 1'b1;
      if (lsu_busy) begin
        de_hold_c  = 1'b1;
        em_hold_c  = 1'b1;
        mw_flush_c = 1'b1;
      end
      if (ifu_ready) next_state = RUN;
    end else if (lsu_busy) begin
      pc_hold_c  = 1'b1;
      fd_hold_c  = 1'b1;
      de_hold_c  = 1'b1;
      em_hold_c  = 1'b1;
      mw_flush_c = 1'b1;
    end else if (ex_jump) begin
      redirect_c = 1'b1;
      fd_flush_c = 1'b1;
      de_flush_c = 1'b1;
      next_state = ifu_ready ? RUN : DRAIN;
    end else if (insert_nop) begin
      pc_hold_c  = 1'b1;
      fd_hold_c  = 1'b1;
      de_flush_c = 1'b1;
    end else if (!ifu_ready) begin
      pc_hold_c  = 1'b1;
      fd_flush_c = 1'b1;
    end
  end

  // Output stage: reset forces all bubbles; a flush always masks its hold.
  always_comb begin
    if (rst) begin
      pc_hold      = 1'b0;
      fd_hold      = 1'b0;
      de_hold      = 1'b0;
      em_hold      = 1'b0;
      fd_flush     = 1'b1;
      de_flush     = 1'b1;
      em_flush     = 1'b1;
      mw_flush     = 1'b1;
      redirect     = 1'b0;
      redirect_src = 1'b0;
    end else begin
      pc_hold      = pc_hold_c;
      fd_hold      = fd_hold_c & ~fd_flush_c;
      de_hold      = de_hold_c & ~de_flush_c;
      em_hold      = em_hold_c & ~em_flush_c;
      fd_flush     = fd_flush_c;
      de_flush     = de_flush_c;
      em_flush     = em_flush_c;
      mw_flush     = mw_flush_c;
      redirect     = redirect_c;
      redirect_src = redirect_src_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  core_sat_cnt #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_hold),
    .clr   (1'b0),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Directed self-checking bench for core_pipe_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_core_pipe_ctrl;
  import core_pkg::*;

  logic        clk, rst;
  logic        insert_nop, ex_jump, trap_req, ifu_ready, lsu_busy;
  logic        pc_hold, fd_hold, de_hold, em_hold;
  logic        fd_flush, de_flush, em_flush, mw_flush;
  logic        redirect, redirect_src;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_cnt;

  // {pc,fd,de,em hold, fd,de,em,mw flush, redirect, redirect_src}
  logic [9:0] ctl;
  assign ctl = {pc_hold, fd_hold, de_hold, em_hold,
                fd_flush, de_flush, em_flush, mw_flush, redirect, redirect_src};

  localparam logic [9:0] C_IDLE  = 10'b0000_0000_00;
  localparam logic [9:0] C_RST   = 10'b0000_1111_00;
  localparam logic [9:0] C_NOP   = 10'b1100_0100_00;
  localparam logic [9:0] C_JUMP  = 10'b0000_1100_10;
  localparam logic [9:0] C_DRAIN = 10'b1000_1000_00;
  localparam logic [9:0] C_WAIT  = 10'b1111_0001_00;
  localparam logic [9:0] C_TRAP  = 10'b0000_1111_11;
  localparam logic [9:0] C_DRBSY = 10'b1011_1001_00;

  core_pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .insert_nop   (insert_nop),
    .ex_jump      (ex_jump),
    .trap_req     (trap_req),
    .ifu_ready    (ifu_ready),
    .lsu_busy     (lsu_busy),
    .pc_hold      (pc_hold),
    .fd_hold      (fd_hold),
    .de_hold      (de_hold),
    .em_hold      (em_hold),
    .fd_flush     (fd_flush),
    .de_flush     (de_flush),
    .em_flush     (em_flush),
    .mw_flush     (mw_flush),
    .redirect     (redirect),
    .redirect_src (redirect_src),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge, apply inputs, let logic settle.
  task automatic step(input logic trap, input logic jump, input logic nop,
                      input logic ifu, input logic busy);
    @(negedge clk);
    trap_req   = trap;
    ex_jump    = jump;
    insert_nop = nop;
    ifu_ready  = ifu;
    lsu_busy   = busy;
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (ctl !== C_RST) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", ctl, C_RST);
    end
    n_checks++;
    if (stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want %b", ctl, C_IDLE);
    end
    exp_cnt = 32'd0;
  endtask

  task automatic test_insert_nop;
    step(0, 0, 1, 1, 0);
    n_checks++;
    if (ctl !== C_NOP) begin
      n_fail++; $display("FAIL nop_cycle: got %b want %b", ctl, C_NOP);
    end
    exp_cnt = exp_cnt + 1;
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++; $display("FAIL nop_release: got %b want %b", ctl, C_IDLE);
    end
    n_checks++;
    if (stall_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL nop_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_jump_drain;
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (ctl !== C_JUMP) begin
      n_fail++; $display("FAIL jump_cycle0: got %b want %b", ctl, C_JUMP);
    end
    for (int i = 0; i < 3; i++) begin
      // Two more cycles without a fetch, then the fetch arrives (still discarded).
      step(0, 0, 0, (i == 2), 0);
      exp_cnt = exp_cnt + 1;
      n_checks++;
      if (ctl !== C_DRAIN) begin
        n_fail++; $display("FAIL jump_drain%0d: got %b want %b", i, ctl, C_DRAIN);
      end
    end
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (ctl !== C_IDLE || dut.state !== RUN) begin
      n_fail++; $display("FAIL jump_back_to_run: got %b st=%0d want %b st=0",
                         ctl, dut.state, C_IDLE);
    end
    n_checks++;
    if (stall_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL jump_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_trap_pending;
    for (int i = 0; i < 4; i++) begin
      // trap_req only in the first cycle; the controller must remember it.
      step((i == 0), 0, 0, 1, 1);
      exp_cnt = exp_cnt + 1;
      n_checks++;
      if (ctl !== C_WAIT) begin
        n_fail++; $display("FAIL trap_wait%0d: got %b want %b", i, ctl, C_WAIT);
      end
    end
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (ctl !== C_TRAP) begin
      n_fail++; $display("FAIL trap_take: got %b want %b", ctl, C_TRAP);
    end
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++; $display("FAIL trap_after: got %b want %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_trap_vs_jump;
    step(1, 1, 0, 1, 0);
    n_checks++;
    if (ctl !== C_TRAP) begin
      n_fail++; $display("FAIL trap_beats_jump: got %b want %b", ctl, C_TRAP);
    end
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++; $display("FAIL trap_jump_after: got %b want %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_drain_busy;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    exp_cnt = exp_cnt + 1;
    n_checks++;
    if (ctl !== C_DRBSY) begin
      n_fail++; $display("FAIL drain_busy: got %b want %b", ctl, C_DRBSY);
    end
    step(0, 0, 0, 1, 0);
    exp_cnt = exp_cnt + 1;
    n_checks++;
    if (ctl !== C_DRAIN) begin
      n_fail++; $display("FAIL drain_exit: got %b want %b", ctl, C_DRAIN);
    end
  endtask

  task automatic test_run_stalls;
    step(0, 0, 0, 1, 1);
    exp_cnt = exp_cnt + 1;
    n_checks++;
    if (ctl !== C_WAIT) begin
      n_fail++; $display("FAIL lsu_stall: got %b want %b", ctl, C_WAIT);
    end
    step(0, 0, 0, 0, 0);
    exp_cnt = exp_cnt + 1;
    n_checks++;
    if (ctl !== C_DRAIN) begin
      n_fail++; $display("FAIL fetch_stall: got %b want %b", ctl, C_DRAIN);
    end
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (stall_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL stall_total: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_saturation;
    @(negedge clk);
    force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 0);
      @(posedge clk);
      #1;
      n_checks++;
      if (stall_cnt !== 32'hFFFF_FFFF) begin
        n_fail++; $display("FAIL sat_cycle%0d: got %h want ffffffff", i, stall_cnt);
      end
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid_trap;
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    n_checks++;
    if (dut.state !== TRAP_PEND) begin
      n_fail++; $display("FAIL mid_trap_state: got %0d want %0d", dut.state, TRAP_PEND);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_RST || stall_cnt !== 32'd0 || dut.state !== RUN) begin
      n_fail++; $display("FAIL mid_trap_reset: got %b cnt=%h st=%0d want %b cnt=0 st=0",
                         ctl, stall_cnt, dut.state, C_RST);
    end
    @(negedge clk);
    rst = 1'b0;
    lsu_busy = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ctl !== C_IDLE || stall_cnt !== 32'd0) begin
        n_fail++; $display("FAIL post_reset%0d: got %b cnt=%0d want %b cnt=0",
                           i, ctl, stall_cnt, C_IDLE);
      end
      step(0, 0, 0, 1, 0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    insert_nop = 1'b0;
    ex_jump    = 1'b0;
    trap_req   = 1'b0;
    ifu_ready  = 1'b1;
    lsu_busy   = 1'b0;
    exp_cnt    = 32'd0;

    test_reset;
    test_insert_nop;
    test_jump_drain;
    test_trap_pending;
    test_trap_vs_jump;
    test_drain_busy;
    test_run_stalls;
    test_saturation;
    test_reset_mid_trap;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
